// File: rtl/uart_rx_buffered_pkg.sv
// Shared definitions for the buffered UART receiver: FSM encoding, tick
// positions within a bit period, and the 3-sample majority voter.
package uart_rx_buffered_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  localparam logic [3:0] TICK_MID_LO = 4'd7;
  localparam logic [3:0] TICK_MID_HI = 4'd9;
  localparam logic [3:0] TICK_LAST   = 4'd15;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_buffered_byte_fifo.sv
// First-word-fall-through byte FIFO. Pointers carry an extra MSB so that
// full/empty and the occupancy fall out of a plain pointer difference.
module byte_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      din,
  output logic                  full,
  input  logic                  pop,
  output logic [WIDTH-1:0]      dout,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int                  DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0] LVL_MAX = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [DEPTH_LOG2:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2:0] rptr_q, rptr_d;
  logic                do_push, do_pop;

  assign level   = wptr_q - rptr_q;
  assign empty   = (wptr_q == rptr_q);
  assign full    = (level == LVL_MAX);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push while full still lands.
  assign do_push = push && (!full || do_pop);
  assign wptr_d  = do_push ? wptr_q + PTR_ONE : wptr_q;
  assign rptr_d  = do_pop  ? rptr_q + PTR_ONE : rptr_q;
  assign dout    = empty ? '0 : mem_q[rptr_q[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q[DEPTH_LOG2-1:0]] <= din;
    end
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// 16x-oversampling UART receiver with majority-vote sampling feeding a FWFT
// byte FIFO; reports framing errors and overruns as one-clock pulses.
module uart_rx_buffered
  import uart_rx_buffered_pkg::*;
#(
  parameter int DATA_BITS       = 8,
  parameter int FIFO_DEPTH_LOG2 = 2,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       baudclk16,
  input  logic                       rx,
  output logic [DATA_BITS-1:0]       data,
  output logic                       ready,
  input  logic                       read,
  output logic                       frame_err,
  output logic                       overrun,
  output logic [FIFO_DEPTH_LOG2:0]   level,
  output logic [1:0]                 dbg_state
);

  // Handshake: data is valid whenever ready=1; a cycle with ready=1 and
  // read=1 pops the head, and read while ready=0 has no effect.

  localparam int             BCW      = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] BIT_ONE  = BCW'(1);

  rx_state_e              state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic [3:0]             tick_cnt_q;
  logic [BCW-1:0]         bit_cnt_q;
  logic [DATA_BITS-1:0]   shreg_q;
  logic                   s_lo_q, s_mid_q;
  logic                   maj, tick_mid, tick_last;
  logic                   push_req, ferr_d;
  logic                   frame_err_q, overrun_q;
  logic                   fifo_full, fifo_empty;

  assign rx_s      = sync_q[SYNC_STAGES-1];
  assign maj       = majority3(s_lo_q, s_mid_q, rx_s);
  assign tick_mid  = baudclk16 && (tick_cnt_q == TICK_MID_HI);
  assign tick_last = baudclk16 && (tick_cnt_q == TICK_LAST);
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (baudclk16 && !rx_s) state_d = ST_START;
      ST_START: begin
        if (tick_mid && maj)  state_d = ST_IDLE;
        else if (tick_last)   state_d = ST_DATA;
      end
      ST_DATA:  if (tick_last && (bit_cnt_q == BIT_LAST)) state_d = ST_STOP;
      // Leaving at mid-stop lets a back-to-back start edge be caught.
      ST_STOP:  if (tick_mid) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    push_req = 1'b0;
    ferr_d   = 1'b0;
    if (state_q == ST_STOP && tick_mid) begin
      push_req = maj;
      ferr_d   = !maj;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      s_lo_q     <= 1'b1;
      s_mid_q    <= 1'b1;
    end else if (baudclk16) begin
      if (state_q == ST_IDLE) begin
        tick_cnt_q <= '0;
      end else begin
        tick_cnt_q <= tick_cnt_q + 4'd1;
      end
      if (tick_cnt_q == TICK_MID_LO)        s_lo_q  <= rx_s;
      if (tick_cnt_q == TICK_MID_LO + 4'd1) s_mid_q <= rx_s;
      if (state_q == ST_START && tick_cnt_q == TICK_LAST) begin
        bit_cnt_q <= '0;
      end
      if (state_q == ST_DATA) begin
        if (tick_cnt_q == TICK_MID_HI) begin
          shreg_q <= {maj, shreg_q[DATA_BITS-1:1]};
        end
        if (tick_cnt_q == TICK_LAST && bit_cnt_q != BIT_LAST) begin
          bit_cnt_q <= bit_cnt_q + BIT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= ferr_d;
      overrun_q   <= push_req && fifo_full && !read;
    end
  end

  byte_fifo #(
    .WIDTH      (DATA_BITS),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .din   (shreg_q),
    .full  (fifo_full),
    .pop   (read),
    .dout  (data),
    .empty (fifo_empty),
    .level (level)
  );

  assign ready     = !fifo_empty;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Bench for uart_rx_buffered: serial frames are driven on rx, accepted bytes
// are queued as expectations and compared by a monitor whenever a pop occurs.
module tb_uart_rx_buffered;

  localparam int BAUD_DIV = 27;
  localparam int BIT_CLK  = 16 * BAUD_DIV;

  logic       clk = 1'b0;
  logic       reset, baudclk16, rx, read, read_drv, tie_mode;
  logic [7:0] data;
  logic       ready, frame_err, overrun;
  logic [2:0] level;
  logic [1:0] dbg_state;

  logic [7:0] exp_q[$];
  logic [7:0] exp_byte;
  int         checks = 0, errors = 0;
  int         ferr_cnt = 0, ovr_cnt = 0;
  int         f0, o0, baud_cnt = 0;
  logic       prev_ready = 1'b0, prev_ferr = 1'b0, prev_ovr = 1'b0;

  uart_rx_buffered dut (
    .clk       (clk),
    .reset     (reset),
    .baudclk16 (baudclk16),
    .rx        (rx),
    .data      (data),
    .ready     (ready),
    .read      (read),
    .frame_err (frame_err),
    .overrun   (overrun),
    .level     (level),
    .dbg_state (dbg_state)
  );

  // clock / baud tick / reset-free drivers
  always #10 clk = ~clk;

  initial begin
    baudclk16 = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (baud_cnt == BAUD_DIV - 1) begin
        baud_cnt  = 0;
        baudclk16 = 1'b1;
      end else begin
        baud_cnt  = baud_cnt + 1;
        baudclk16 = 1'b0;
      end
    end
  end

  assign read = tie_mode ? ready : read_drv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (ready && read) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop: got 0x%0h expected no byte at %0t", data, $time);
        end else begin
          exp_byte = exp_q.pop_front();
          check("pop_data", {24'd0, data}, {24'd0, exp_byte});
        end
      end
      if (frame_err) begin
        ferr_cnt++;
        check("frame_err_width", {31'd0, prev_ferr}, 32'd0);
        check("err_exclusive", {31'd0, overrun}, 32'd0);
      end
      if (overrun) begin
        ovr_cnt++;
        check("overrun_width", {31'd0, prev_ovr}, 32'd0);
      end
      if (tie_mode && ready) begin
        check("tie_ready_width", {31'd0, prev_ready}, 32'd0);
      end
      prev_ready = ready;
      prev_ferr  = frame_err;
      prev_ovr   = overrun;
    end
  end

  task automatic drive_bit(input logic b, input int clocks);
    rx = b;
    repeat (clocks) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    drive_bit(1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) drive_bit(d[i], BIT_CLK);
    drive_bit(stop_bit, BIT_CLK);
    rx = 1'b1;
  endtask

  task automatic pop_one();
    check("pop_ready", {31'd0, ready}, 32'd1);
    read_drv = 1'b1;
    @(posedge clk);
    #1;
    read_drv = 1'b0;
  endtask

  // watchdog
  initial begin
    #(4_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  logic [7:0] tv [5] = '{8'h00, 8'hFF, 8'h3C, 8'h81, 8'h55};
  logic [7:0] b33 = 8'h33;
  logic [7:0] rnd;

  initial begin
    rx = 1'b1; reset = 1'b1; read_drv = 1'b0; tie_mode = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_data", {24'd0, data}, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_level", {29'd0, level}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_ovr", {31'd0, overrun}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    reset = 1'b0;
    drive_bit(1'b1, BIT_CLK);

    // 1: single byte, ready only after the stop-bit mid-sample
    exp_q.push_back(8'hA5);
    drive_bit(1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) drive_bit(exp_q[0][i], BIT_CLK);
    drive_bit(1'b1, 4 * BAUD_DIV);
    check("t1_early_ready", {31'd0, ready}, 32'd0);
    drive_bit(1'b1, BIT_CLK - 4 * BAUD_DIV);
    check("t1_ready", {31'd0, ready}, 32'd1);
    check("t1_data", {24'd0, data}, 32'hA5);
    check("t1_level", {29'd0, level}, 32'd1);
    pop_one();
    check("t1_empty", {31'd0, ready}, 32'd0);

    // 2: five back-to-back frames into a four-deep FIFO
    o0 = ovr_cnt;
    for (int i = 0; i < 4; i++) exp_q.push_back(tv[i]);
    for (int i = 0; i < 5; i++) send_frame(tv[i], 1'b1);
    drive_bit(1'b1, BAUD_DIV);
    check("t2_level", {29'd0, level}, 32'd4);
    check("t2_overrun", ovr_cnt - o0, 32'd1);
    for (int i = 0; i < 4; i++) pop_one();
    check("t2_level_after", {29'd0, level}, 32'd0);

    // 3: framing error
    f0 = ferr_cnt;
    send_frame(8'h5A, 1'b0);
    drive_bit(1'b1, BIT_CLK);
    check("t3_ferr", ferr_cnt - f0, 32'd1);
    check("t3_ready", {31'd0, ready}, 32'd0);
    check("t3_level", {29'd0, level}, 32'd0);

    // 4: short glitch rejected, then a normal byte
    f0 = ferr_cnt;
    drive_bit(1'b0, 3 * BAUD_DIV);
    drive_bit(1'b1, 2 * BIT_CLK);
    check("t4_state_idle", {30'd0, dbg_state}, 32'd0);
    check("t4_no_ferr", ferr_cnt - f0, 32'd0);
    check("t4_ready", {31'd0, ready}, 32'd0);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    drive_bit(1'b1, BAUD_DIV);
    pop_one();

    // 5: reset in the middle of bit 4, with a byte already buffered
    f0 = ferr_cnt;
    o0 = ovr_cnt;
    send_frame(8'h0F, 1'b1);
    drive_bit(1'b1, BAUD_DIV);
    check("t5_pre_level", {29'd0, level}, 32'd1);
    drive_bit(1'b0, BIT_CLK);
    for (int i = 0; i < 4; i++) drive_bit(b33[i], BIT_CLK);
    drive_bit(b33[4], BIT_CLK / 2);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("t5_data", {24'd0, data}, 32'd0);
    check("t5_ready", {31'd0, ready}, 32'd0);
    check("t5_level", {29'd0, level}, 32'd0);
    check("t5_ferr", {31'd0, frame_err}, 32'd0);
    check("t5_ovr", {31'd0, overrun}, 32'd0);
    check("t5_state", {30'd0, dbg_state}, 32'd0);
    drive_bit(1'b1, BIT_CLK);
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1);
    drive_bit(1'b1, BAUD_DIV);
    pop_one();
    check("t5_no_err_pulses", (ferr_cnt - f0) + (ovr_cnt - o0), 32'd0);

    // 6: read tied to ready, back-to-back frames
    o0 = ovr_cnt;
    tie_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rnd = 8'($urandom_range(0, 255));
      exp_q.push_back(rnd);
      send_frame(rnd, 1'b1);
    end
    drive_bit(1'b1, BIT_CLK);
    tie_mode = 1'b0;
    check("t6_drained", exp_q.size(), 32'd0);
    check("t6_no_overrun", ovr_cnt - o0, 32'd0);
    check("t6_level", {29'd0, level}, 32'd0);

    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
